// File: rtl/pio_output_pulse.sv
// Avalon-MM output PIO with atomic SET/CLR/TOGGLE ports and a self-clearing one-shot PULSE.
// Define PIO_PRESCALE_EN to add the PRESCALE register (address 6) that slows the pulse tick.
module pio_output_pulse #(
    parameter int unsigned       DATA_W      = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter int unsigned       PULSE_CNT_W = 16,
    parameter int unsigned       PRESCALE_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrSet      = 3'd1;
    localparam logic [2:0] AddrClr      = 3'd2;
    localparam logic [2:0] AddrToggle   = 3'd3;
    localparam logic [2:0] AddrPulseLen = 3'd4;
    localparam logic [2:0] AddrPulse    = 3'd5;
    localparam logic [2:0] AddrPrescale = 3'd6;

    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      mask_q, mask_d;
    logic [PULSE_CNT_W-1:0] len_q, len_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic [PULSE_CNT_W-1:0] len_eff;
    logic [DATA_W-1:0]      wd;
    logic                   wr_en;
    logic                   pulse_start;
    logic                   tick;
    logic                   unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wd           = writedata[DATA_W-1:0];
    assign pulse_start  = wr_en && (address == AddrPulse) && (wd != '0);
    assign len_eff      = (len_q == '0) ? PULSE_CNT_W'(1) : len_q;
    assign unused_wdata = ^writedata;

`ifdef PIO_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    assign tick = (pre_cnt_q == prescale_q);

    // Restarting on a pulse start makes the first tick land exactly PRESCALE+1 clocks later.
    always_comb begin
        prescale_d = prescale_q;
        if (wr_en && (address == AddrPrescale)) begin
            prescale_d = writedata[PRESCALE_W-1:0];
        end
        if (pulse_start || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end
`else
    logic [PRESCALE_W-1:0] unused_prescale;

    assign unused_prescale = '0;
    assign tick            = 1'b1;
`endif

    // Expiry is resolved first so a same-cycle bus write operates on the cleared value.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        len_d  = len_q;

        if ((mask_q != '0) && tick) begin
            if (cnt_q <= PULSE_CNT_W'(1)) begin
                data_d = data_q & ~mask_q;
                mask_d = '0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - PULSE_CNT_W'(1);
            end
        end

        if (wr_en) begin
            case (address)
                AddrData:     data_d = wd;
                AddrSet:      data_d = data_d | wd;
                AddrClr:      data_d = data_d & ~wd;
                AddrToggle:   data_d = data_d ^ wd;
                AddrPulseLen: len_d  = writedata[PULSE_CNT_W-1:0];
                AddrPulse: begin
                    if (pulse_start) begin
                        // Old mask bits not re-armed drop immediately on a restart.
                        data_d = (data_d & ~mask_q) | wd;
                        mask_d = wd;
                        cnt_d  = len_eff;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:     readdata = 32'(data_q);
            AddrPulseLen: readdata = 32'(len_q);
            AddrPulse:    readdata = 32'(mask_q);
`ifdef PIO_PRESCALE_EN
            AddrPrescale: readdata = 32'(prescale_q);
`endif
            default:      readdata = '0;
        endcase
    end

    assign out_port = data_q;

endmodule

// File: tb/tb_pio_output_pulse.sv
// Bench for pio_output_pulse: directed scenarios plus random bus traffic checked every cycle
// against a model that tracks pulse expiry as an absolute cycle number.
module tb_pio_output_pulse;

    localparam logic [15:0] RV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [15:0] out_port;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pio_output_pulse #(
        .DATA_W      (16),
        .RESET_VALUE (RV),
        .PULSE_CNT_W (16),
        .PRESCALE_W  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: state plus the absolute cycle at which the active pulse ends.
    logic [15:0] m_data = RV;
    logic [15:0] m_mask = 16'd0;
    logic [15:0] m_len  = 16'd0;
    logic [15:0] m_pre  = 16'd0;
    longint      cyc    = 0;
    longint      m_end  = 0;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {16'd0, m_data};
            3'd4: return {16'd0, m_len};
            3'd5: return {16'd0, m_mask};
`ifdef PIO_PRESCALE_EN
            3'd6: return {16'd0, m_pre};
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [15:0] wd;
        longint      len1;
        cyc++;
        if (!reset_n) begin
            m_data = RV;
            m_mask = 16'd0;
            m_len  = 16'd0;
            m_pre  = 16'd0;
        end else begin
            if (m_mask != 16'd0 && cyc == m_end) begin
                m_data = m_data & ~m_mask;
                m_mask = 16'd0;
            end
            if (chipselect && !write_n) begin
                wd = writedata[15:0];
                case (address)
                    3'd0: m_data = wd;
                    3'd1: m_data = m_data | wd;
                    3'd2: m_data = m_data & ~wd;
                    3'd3: m_data = m_data ^ wd;
                    3'd4: m_len  = wd;
                    3'd5: begin
                        if (wd != 16'd0) begin
                            m_data = (m_data & ~m_mask) | wd;
                            m_mask = wd;
                            len1   = (m_len == 16'd0) ? 1 : longint'(m_len);
                            m_end  = cyc + len1 * (longint'(m_pre) + 1);
                        end
                    end
`ifdef PIO_PRESCALE_EN
                    3'd6: m_pre = wd;
`endif
                    default: ;
                endcase
            end
        end
        #1;
        check("model out_port", {16'd0, out_port}, {16'd0, m_data});
        check("model readdata", readdata, m_read(address));
    end

    // Drive one write at a negedge; returns at the next negedge with the bus idle.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    // Counts negedge samples on which every bit of m is high.
    task automatic measure(input string name, input logic [15:0] m, input int exp);
        int n = 0;
        while (((out_port & m) == m) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp);
    endtask

    initial begin
        int unsigned a;
        logic [31:0] d;

        idle(2);
        reset_n = 1'b1;
        check("reset out_port", {16'd0, out_port}, 32'h0000A5A5);
        rd("reset rd0", 3'd0, 32'h0000A5A5);
        wr(3'd0, 32'h0000_1234);
        check("data out_port", {16'd0, out_port}, 32'h00001234);
        rd("data rd0", 3'd0, 32'h00001234);

        wr(3'd0, 32'hFFFF_00F0);
        wr(3'd1, 32'hFFFF_000F);
        check("set", {16'd0, out_port}, 32'h000000FF);
        wr(3'd2, 32'hFFFF_00F0);
        check("clr", {16'd0, out_port}, 32'h0000000F);
        wr(3'd3, 32'hFFFF_FFFF);
        check("toggle", {16'd0, out_port}, 32'h0000FFF0);
        rd("rd set", 3'd1, 32'd0);
        rd("rd clr", 3'd2, 32'd0);
        rd("rd toggle", 3'd3, 32'd0);
        rd("rd reserved", 3'd7, 32'd0);

        wr(3'd0, 32'd0);
        wr(3'd4, 32'd5);
        rd("rd pulse_len", 3'd4, 32'd5);
        wr(3'd5, 32'h3);
        check("pulse start", {16'd0, out_port}, 32'h3);
        rd("pulse mask active", 3'd5, 32'h3);
        measure("pulse len 5", 16'h3, 5);
        check("pulse end", {16'd0, out_port}, 32'h0);
        rd("pulse mask idle", 3'd5, 32'h0);
        wr(3'd4, 32'd0);
        wr(3'd5, 32'h1);
        measure("pulse len 0", 16'h1, 1);

        wr(3'd4, 32'd4);
        wr(3'd0, 32'd0);
        wr(3'd5, 32'h1);
        idle(1);
        wr(3'd5, 32'h2);
        check("restart drop", {16'd0, out_port}, 32'h2);
        measure("restart len", 16'h2, 4);
        check("restart end", {16'd0, out_port}, 32'h0);

        wr(3'd5, 32'h1);
        idle(3);
        wr(3'd1, 32'h1);
        check("set on expiry", {16'd0, out_port}, 32'h1);
        idle(3);
        check("set on expiry hold", {16'd0, out_port}, 32'h1);
        wr(3'd0, 32'd0);
        wr(3'd5, 32'h3);
        idle(3);
        wr(3'd1, 32'h1);
        check("set on expiry mask3", {16'd0, out_port}, 32'h1);
        wr(3'd0, 32'd0);
        wr(3'd5, 32'h1);
        idle(3);
        wr(3'd0, 32'hFF);
        check("data on expiry", {16'd0, out_port}, 32'hFF);
        idle(2);
        check("data on expiry hold", {16'd0, out_port}, 32'hFF);

        wr(3'd0, 32'd0);
        wr(3'd5, 32'h1);
        #2 reset_n = 1'b0;
        #1 check("async reset", {16'd0, out_port}, 32'h0000A5A5);
        @(negedge clk);
        reset_n = 1'b1;
        rd("reset mask", 3'd5, 32'd0);
        rd("reset len", 3'd4, 32'd0);
        idle(8);
        check("no spurious clear", {16'd0, out_port}, 32'h0000A5A5);

        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 7);
`ifdef PIO_PRESCALE_EN
            if (a == 6) a = 7;
`endif
            d = $urandom;
            if (a == 4) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            if (a == 5 && $urandom_range(0, 3) == 0) d = d & 32'hFFFF_0000;
            address    = 3'(a);
            writedata  = d;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 1) == 0);
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        wr(3'd0, 32'd0);
        wr(3'd6, 32'd3);
`ifdef PIO_PRESCALE_EN
        rd("rd prescale", 3'd6, 32'd3);
        wr(3'd4, 32'd2);
        wr(3'd5, 32'h1);
        measure("prescaled pulse", 16'h1, 8);
`else
        rd("rd addr6", 3'd6, 32'd0);
        wr(3'd4, 32'd2);
        wr(3'd5, 32'h1);
        measure("unscaled pulse", 16'h1, 2);
`endif
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
